// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- main control FSM of the multicycle CPU.
// Sequences the shared memory port, the single ALU and the instruction
// register over several cycles per instruction and drives every datapath
// enable and mux select.  Emits a one-cycle retire pulse per instruction.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   op, funct         decoded instruction fields (stable DECODE..next FETCH)
//   cond_ok           condition-check result for the current flags
//   ir_write, pc_write, reg_write, mem_write, flag_write   write enables
//   adr_src, alu_src_a, alu_src_b, result_src, alu_op      datapath selects
//   retire            one-cycle pulse in the final cycle of an instruction
//   state_o           current state encoding (debug)
module multicycle_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic       cond_ok,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic       mem_write,
   output logic       flag_write,
   output logic       adr_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic       alu_op,
   output logic       retire,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   // Pure state-decoded control fields.  Enables here are "requested";
   // condition / funct / reset gating is applied at the outputs.
   typedef struct packed {
      logic       ir_wr;
      logic       pc_wr_always;
      logic       pc_wr_cond;
      logic       reg_wr;
      logic       mem_wr;
      logic       flag_wr;
      logic       ret;
      logic       adr;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [1:0] res;
      logic       aluop;
   } ctl_t;

   state_t state;
   ctl_t   ctl;
   logic   nowrite;
   logic   illegal_retire;

   function automatic state_t next_state(input state_t s, input logic [1:0] o,
                                         input logic [5:0] f);
      state_t n;
      case (s)
         FETCH:  n = DECODE;
         DECODE: begin
            case (o)
               2'b00:   n = f[5] ? EXECI : EXECR;
               2'b01:   n = MEMADR;
               2'b10:   n = BRANCH;
               default: n = FETCH;   // illegal op retires as a NOP
            endcase
         end
         MEMADR:  n = f[0] ? MEMRD : MEMWR;
         MEMRD:   n = MEMWB;
         EXECR:   n = ALUWB;
         EXECI:   n = ALUWB;
         default: n = FETCH;        // MEMWB, MEMWR, ALUWB, BRANCH
      endcase
      return n;
   endfunction

   function automatic ctl_t decode_ctl(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.ir_wr = 1'b1; c.pc_wr_always = 1'b1;
            c.src_a = 2'b01; c.src_b = 2'b10; c.res = 2'b10;
         end
         DECODE: begin
            c.src_a = 2'b01; c.src_b = 2'b10; c.res = 2'b10;
         end
         MEMADR: begin
            c.src_a = 2'b00; c.src_b = 2'b01;
         end
         MEMRD:  c.adr = 1'b1;
         MEMWB: begin
            c.res = 2'b01; c.reg_wr = 1'b1; c.ret = 1'b1;
         end
         MEMWR: begin
            c.adr = 1'b1; c.mem_wr = 1'b1; c.ret = 1'b1;
         end
         EXECR: begin
            c.src_a = 2'b00; c.src_b = 2'b00; c.aluop = 1'b1; c.flag_wr = 1'b1;
         end
         EXECI: begin
            c.src_a = 2'b00; c.src_b = 2'b01; c.aluop = 1'b1; c.flag_wr = 1'b1;
         end
         ALUWB: begin
            c.res = 2'b00; c.reg_wr = 1'b1; c.ret = 1'b1;
         end
         BRANCH: begin
            c.src_a = 2'b00; c.src_b = 2'b01; c.res = 2'b10;
            c.pc_wr_cond = 1'b1; c.ret = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // State register plus registered decode of the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH;
         ctl   <= decode_ctl(FETCH);
      end else begin
         state <= next_state(state, op, funct);
         ctl   <= decode_ctl(next_state(state, op, funct));
      end
   end

   // TST/TEQ/CMP/CMN (cmd 1000..1011) only set flags, never write a register.
   assign nowrite        = (funct[4:3] == 2'b10);
   assign illegal_retire = (state == DECODE) && (op == 2'b11);

   // Enables are forced low while rst is high; selects keep FETCH values.
   assign ir_write   = ctl.ir_wr & ~rst;
   assign pc_write   = (ctl.pc_wr_always | (ctl.pc_wr_cond & cond_ok)) & ~rst;
   assign reg_write  = ctl.reg_wr & cond_ok & ~((state == ALUWB) & nowrite) & ~rst;
   assign mem_write  = ctl.mem_wr & cond_ok & ~rst;
   assign flag_write = ctl.flag_wr & funct[0] & cond_ok & ~rst;
   assign retire     = (ctl.ret | illegal_retire) & ~rst;
   assign adr_src    = ctl.adr;
   assign alu_src_a  = ctl.src_a;
   assign alu_src_b  = ctl.src_b;
   assign result_src = ctl.res;
   assign alu_op     = ctl.aluop;
   assign state_o    = state;

endmodule
